// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant hold and a bounded tenure per holder.
// Produces a registered one-hot grant, its binary index and a valid flag.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [7:0] iReq,
   output logic [7:0] oGrant,
   output logic [2:0] oIdx,
   output logic       oValid
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [7:0]       grant_q, grant_d;
   logic [2:0]       idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       last_q, last_d;

   logic [3:0]       pick;
   logic             release_now;

   // Returns {found, index} of the first requester after 'last', wrapping; 'last' itself is lowest priority.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] pos;
      res = 4'b0000;
      for (int k = 8; k >= 1; k--) begin
         pos = last + 3'(k);
         if (req[pos]) res = {1'b1, pos};
      end
      return res;
   endfunction

   // While granted, last_q equals the holder, so one scan serves both states.
   // A holder released by dropping its request is already absent from iReq.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      pick        = rr_pick(iReq, last_q);
      release_now = (state_q == GRANT) && (!iReq[idx_q] || (cnt_q == HOLD_LAST));

      if (state_q == IDLE || release_now) begin
         if (pick[3]) begin
            state_d = GRANT;
            grant_d = 8'b1 << pick[2:0];
            idx_d   = pick[2:0];
            valid_d = 1'b1;
            cnt_d   = '0;
            last_d  = pick[2:0];
         end else begin
            state_d = IDLE;
            grant_d = 8'h00;
            idx_d   = 3'd0;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         grant_q <= 8'h00;
         idx_q   <= 3'd0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         last_q  <= 3'd7;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign oGrant = grant_q;
   assign oIdx   = idx_q;
   assign oValid = valid_q;

endmodule
